soc_apb_bridge: RTL and testbench

//  Converts the single-outstanding req/gnt/rvalid SoC interconnect port into APB3 master transfers.

---
 rtl/soc_apb_bridge_pkg.sv | 22 ++
 rtl/soc_apb_bridge_wdog.sv | 45 ++++
 rtl/soc_apb_bridge.sv | 126 ++++++++++++
 tb/tb_soc_apb_bridge.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/soc_apb_bridge_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : soc_apb_bridge_pkg
//  Brief    : Shared types and constants for the SoC-to-APB3 bridge.
//  Revision : 1.0  initial release
// ============================================================================
package soc_apb_bridge_pkg;

   // Bridge transfer phases.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      RESP   = 2'd3
   } state_e;

   // Read data returned when the watchdog aborts a hung ACCESS phase.
   // Sized generously; the bridge slices it to its data width.
   localparam logic [63:0] TIMEOUT_ERR_RDATA = '0;

endpackage
`default_nettype wire

// File: rtl/soc_apb_bridge_wdog.sv
`default_nettype none
// ============================================================================
//  Module   : soc_apb_bridge_wdog
//  Brief    : Saturating ACCESS-phase counter. Clear reloads zero, enable
//             counts one stalled cycle, expire flags the last allowed cycle.
//             TIMEOUT_CYCLES = 0 disables expiry.
//  Revision : 1.0  initial release
// ============================================================================
module soc_apb_bridge_wdog #(
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clear,
   input  logic enable,
   output logic expire
);

   localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [CW-1:0] CNT_MAX = '1;

   logic [CW-1:0] count;

   // Count stalled ACCESS cycles; holds at all-ones instead of wrapping.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable && (count != CNT_MAX)) begin
         count <= count + CW'(1);
      end
   end

   generate
      if (TIMEOUT_CYCLES > 0) begin : g_wdog_on
         localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);
         assign expire = (count == LAST);
      end else begin : g_wdog_off
         assign expire = 1'b0;
      end
   endgenerate

endmodule
`default_nettype wire

// File: rtl/soc_apb_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : soc_apb_bridge
//  Brief    : Single-outstanding req/gnt/rvalid port to APB3 master bridge
//             with SETUP/ACCESS sequencing and an ACCESS-phase watchdog.
//  Revision : 1.0  initial release
// ============================================================================
module soc_apb_bridge
   import soc_apb_bridge_pkg::*;
#(
   parameter int APB_ADDR_WIDTH = 32,
   parameter int APB_DATA_WIDTH = 32,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic                        req_i,
   output logic                        gnt_o,
   input  logic [APB_ADDR_WIDTH-1:0]   addr_i,
   input  logic                        we_i,
   input  logic [APB_DATA_WIDTH/8-1:0] be_i,
   input  logic [APB_DATA_WIDTH-1:0]   wdata_i,
   output logic                        rvalid_o,
   output logic [APB_DATA_WIDTH-1:0]   rdata_o,
   output logic                        err_o,
   output logic [APB_ADDR_WIDTH-1:0]   paddr_o,
   output logic [APB_DATA_WIDTH-1:0]   pwdata_o,
   output logic                        pwrite_o,
   output logic                        psel_o,
   output logic                        penable_o,
   input  logic                        pready_i,
   input  logic [APB_DATA_WIDTH-1:0]   prdata_i,
   input  logic                        pslverr_i
);

   state_e state_q;
   state_e state_d;
   logic   gnt;
   logic   expire;

   // Byte enables are kept with the transfer but APB3 has no PSTRB to drive.
   logic [APB_DATA_WIDTH/8-1:0] unused_be_q;

   // A new request may be accepted while idle or while returning a response.
   assign gnt   = req_i & ((state_q == IDLE) | (state_q == RESP));
   assign gnt_o = gnt;

   // State register.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state decode and APB/response strobes.
   always_comb begin
      state_d   = state_q;
      psel_o    = 1'b0;
      penable_o = 1'b0;
      rvalid_o  = 1'b0;
      case (state_q)
         IDLE: begin
            if (gnt) state_d = SETUP;
         end
         SETUP: begin
            psel_o  = 1'b1;
            state_d = ACCESS;
         end
         ACCESS: begin
            psel_o    = 1'b1;
            penable_o = 1'b1;
            if (pready_i || expire) state_d = RESP;
         end
         RESP: begin
            rvalid_o = 1'b1;
            state_d  = gnt ? SETUP : IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Capture the request payload on grant; held unchanged until the next grant.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         paddr_o     <= '0;
         pwdata_o    <= '0;
         pwrite_o    <= 1'b0;
         unused_be_q <= '0;
      end else if (gnt) begin
         paddr_o     <= addr_i;
         pwdata_o    <= wdata_i;
         pwrite_o    <= we_i;
         unused_be_q <= be_i;
      end
   end

   // Latch the completion result; PREADY takes priority over a same-cycle timeout.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rdata_o <= '0;
         err_o   <= 1'b0;
      end else if (state_q == ACCESS) begin
         if (pready_i) begin
            rdata_o <= pwrite_o ? '0 : prdata_i;
            err_o   <= pslverr_i;
         end else if (expire) begin
            rdata_o <= TIMEOUT_ERR_RDATA[APB_DATA_WIDTH-1:0];
            err_o   <= 1'b1;
         end
      end
   end

   soc_apb_bridge_wdog #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_wdog (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .clear  (state_q == SETUP),
      .enable ((state_q == ACCESS) & ~pready_i),
      .expire (expire)
   );

endmodule
`default_nettype wire

// File: tb/tb_soc_apb_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : tb_soc_apb_bridge
//  Brief    : Self-checking bench for soc_apb_bridge with a configurable APB
//             slave model, vector table and response scoreboard.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_soc_apb_bridge;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int TO = 4;
   localparam int NV = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          req;
   logic          gnt;
   logic [AW-1:0] addr;
   logic          we;
   logic [DW/8-1:0] be;
   logic [DW-1:0] wdata;
   logic          rvalid;
   logic [DW-1:0] rdata;
   logic          err;
   logic [AW-1:0] paddr;
   logic [DW-1:0] pwdata;
   logic          pwrite;
   logic          psel;
   logic          penable;
   logic          pready;
   logic [DW-1:0] prdata;
   logic          pslverr;

   always #5 clk = ~clk;

   soc_apb_bridge #(
      .APB_ADDR_WIDTH (AW),
      .APB_DATA_WIDTH (DW),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk_i     (clk),
      .rst_i     (rst),
      .req_i     (req),
      .gnt_o     (gnt),
      .addr_i    (addr),
      .we_i      (we),
      .be_i      (be),
      .wdata_i   (wdata),
      .rvalid_o  (rvalid),
      .rdata_o   (rdata),
      .err_o     (err),
      .paddr_o   (paddr),
      .pwdata_o  (pwdata),
      .pwrite_o  (pwrite),
      .psel_o    (psel),
      .penable_o (penable),
      .pready_i  (pready),
      .prdata_i  (prdata),
      .pslverr_i (pslverr)
   );

   // ---------------- APB slave model ----------------
   int            wait_cfg   = 0;
   logic          stuck_cfg  = 1'b0;
   logic [DW-1:0] prdata_cfg = '0;
   logic          slverr_cfg = 1'b0;
   int            acc_cnt    = 0;

   // Number of ACCESS cycles seen so far, updated mid-cycle.
   always @(negedge clk) begin
      if (psel && penable) acc_cnt <= acc_cnt + 1;
      else                 acc_cnt <= 0;
   end

   assign pready  = psel & penable & ~stuck_cfg & (acc_cnt > wait_cfg);
   assign prdata  = prdata_cfg;
   assign pslverr = slverr_cfg;

   // ---------------- checking ----------------
   int checks = 0;
   int passes = 0;
   int cyc    = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
   endtask

   typedef struct {
      logic [AW-1:0] addr;
      logic          we;
      logic [DW-1:0] wdata;
      logic [DW-1:0] rdata;
      logic          err;
      int            lat;
      int            npsel;
      int            gcyc;
   } exp_t;

   exp_t          sb[$];
   logic [DW-1:0] last_rdata;
   logic          last_err;

   // Scoreboard monitor: pop/compare on rvalid, check APB stability, push on grant.
   initial begin : monitor
      exp_t e;
      int   n;
      int   psel_cnt;
      psel_cnt = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            sb.delete();
            psel_cnt = 0;
         end else begin
            if (rvalid) begin
               check("rvalid_expected", 64'(sb.size() != 0), 64'd1);
               if (sb.size() != 0) begin
                  e = sb.pop_front();
                  check("rdata", 64'(rdata), 64'(e.rdata));
                  check("err", 64'(err), 64'(e.err));
                  check("latency", 64'(cyc - e.gcyc), 64'(e.lat));
                  check("psel_cycles", 64'(psel_cnt), 64'(e.npsel));
               end
               last_rdata = rdata;
               last_err   = err;
               psel_cnt   = 0;
            end
            if (psel) begin
               psel_cnt++;
               check("psel_owner", 64'(sb.size() != 0), 64'd1);
               if (sb.size() != 0) begin
                  check("paddr_stable", 64'(paddr), 64'(sb[0].addr));
                  check("pwrite_stable", 64'(pwrite), 64'(sb[0].we));
                  if (sb[0].we) check("pwdata_stable", 64'(pwdata), 64'(sb[0].wdata));
               end
            end
            if (gnt) begin
               e.addr  = addr;
               e.we    = we;
               e.wdata = wdata;
               e.gcyc  = cyc;
               if (stuck_cfg || (wait_cfg + 1 > TO)) begin
                  n       = TO;
                  e.rdata = '0;
                  e.err   = 1'b1;
               end else begin
                  n       = wait_cfg + 1;
                  e.rdata = we ? '0 : prdata_cfg;
                  e.err   = slverr_cfg;
               end
               e.lat   = n + 2;
               e.npsel = n + 1;
               sb.push_back(e);
            end
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic do_req(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
      bit ok;
      req = 1'b1; we = w; addr = a; wdata = d; be = '1;
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (gnt) begin ok = 1'b1; break; end
      end
      check("grant_seen", 64'(ok), 64'd1);
      @(posedge clk); #1;
      req = 1'b0;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 40; i++) begin
         if (sb.size() == 0) break;
         @(negedge clk);
      end
      check("response_seen", 64'(sb.size() == 0), 64'd1);
      @(posedge clk); #1;
   endtask

   typedef struct {
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic [DW-1:0] prdata;
      int            waits;
      logic          slverr;
      logic          stuck;
      logic [DW-1:0] exp_rdata;
      logic          exp_err;
   } vec_t;

   vec_t vec[NV];
   int   gc[3];

   initial begin : stim
      vec[0] = '{1'b0, 32'h1A10_1000, 32'h0,         32'hCAFE_F00D, 0, 1'b0, 1'b0, 32'hCAFE_F00D, 1'b0};
      vec[1] = '{1'b1, 32'h1A10_1004, 32'hDEAD_BEEF, 32'h1111_2222, 3, 1'b0, 1'b0, 32'h0,         1'b0};
      vec[2] = '{1'b0, 32'h1A10_2008, 32'h0,         32'h1234_5678, 1, 1'b1, 1'b0, 32'h1234_5678, 1'b1};
      vec[3] = '{1'b1, 32'h1A10_200C, 32'h0BAD_CAFE, 32'h3333_4444, 0, 1'b1, 1'b0, 32'h0,         1'b1};
      vec[4] = '{1'b0, 32'h1A10_3000, 32'h0,         32'h7777_8888, 0, 1'b0, 1'b1, 32'h0,         1'b1};
      vec[5] = '{1'b0, 32'h1A10_3004, 32'h0,         32'h55AA_55AA, 3, 1'b0, 1'b0, 32'h55AA_55AA, 1'b0};
      vec[6] = '{1'b0, 32'h1A10_3008, 32'h0,         32'hA5A5_5A5A, 3, 1'b1, 1'b0, 32'hA5A5_5A5A, 1'b1};
      vec[7] = '{1'b1, 32'h1A10_300C, 32'h0102_0304, 32'h9999_AAAA, 2, 1'b0, 1'b0, 32'h0,         1'b0};

      rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; be = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_gnt", 64'(gnt), 64'd0);
      check("rst_rvalid", 64'(rvalid), 64'd0);
      check("rst_err", 64'(err), 64'd0);
      check("rst_psel", 64'(psel), 64'd0);
      check("rst_penable", 64'(penable), 64'd0);
      check("rst_pwrite", 64'(pwrite), 64'd0);
      check("rst_rdata", 64'(rdata), 64'd0);
      check("rst_paddr", 64'(paddr), 64'd0);
      check("rst_pwdata", 64'(pwdata), 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      // Table-driven single transfers.
      for (int i = 0; i < NV; i++) begin
         wait_cfg   = vec[i].waits;
         stuck_cfg  = vec[i].stuck;
         prdata_cfg = vec[i].prdata;
         slverr_cfg = vec[i].slverr;
         do_req(vec[i].we, vec[i].addr, vec[i].wdata);
         wait_idle();
         check("vec_rdata", 64'(last_rdata), 64'(vec[i].exp_rdata));
         check("vec_err", 64'(last_err), 64'(vec[i].exp_err));
      end

      // Back-to-back reads with req held high.
      wait_cfg = 0; stuck_cfg = 1'b0; slverr_cfg = 1'b0; prdata_cfg = 32'h0BB0_0BB0;
      req = 1'b1; we = 1'b0; addr = 32'h1A10_4000; wdata = '0;
      for (int k = 0; k < 3; k++) begin
         gc[k] = -100;
         for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (gnt) begin gc[k] = cyc; break; end
         end
         if (k > 0) check("b2b_gnt_in_resp", 64'(rvalid), 64'd1);
         @(posedge clk); #1;
         addr = addr + 32'd4;
      end
      req = 1'b0;
      wait_idle();
      check("b2b_spacing_1", 64'(gc[1] - gc[0]), 64'd3);
      check("b2b_spacing_2", 64'(gc[2] - gc[1]), 64'd3);

      // Reset during a stalled ACCESS phase.
      stuck_cfg = 1'b1;
      do_req(1'b0, 32'h1A10_5000, '0);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (penable) break;
      end
      check("mid_rst_in_access", 64'(penable), 64'd1);
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("mid_rst_psel", 64'(psel), 64'd0);
      check("mid_rst_penable", 64'(penable), 64'd0);
      check("mid_rst_rvalid", 64'(rvalid), 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      stuck_cfg = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      wait_cfg = 1; prdata_cfg = 32'h600D_DA7A; slverr_cfg = 1'b0;
      do_req(1'b0, 32'h1A10_5004, '0);
      wait_idle();
      check("post_rst_rdata", 64'(last_rdata), 64'h600D_DA7A);
      check("post_rst_err", 64'(last_err), 64'd0);

      repeat (4) @(posedge clk);
      check("sb_empty_end", 64'(sb.size()), 64'd0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   initial begin : guard
      #200000;
      $display("FAIL global_timeout: simulation did not finish, required finish before 200000ns");
      $fatal(1);
   end

endmodule
`default_nettype wire
